gcd_ctrl: RTL and testbench

Control FSM for the 7-bit subtractive-GCD datapath; it is the driver side of the operand registers' load interface.
- Accepts an operand pair via valid/ready, generates load strobes and mux selects for reg_a/reg_b, and reads comparator/zero flags back.
- Presents the result with a valid/ready handshake.
- Sits between the system-side request interface and the datapath (reg_a, reg_b, subtractor, comparator).

---
 rtl/gcd_pkg.sv | 10 +
 rtl/gcd_iter_cnt.sv | 20 ++
 rtl/gcd_ctrl.sv | 119 +++++++++++
 tb/tb_gcd_ctrl.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/gcd_pkg.sv
// Shared types and constants for the subtractive-GCD controller.
package gcd_pkg;
  typedef enum logic [1:0] {IDLE, CMP, DONE} state_t;

  localparam logic SEL_LOAD = 1'b0;
  localparam logic SEL_SUB  = 1'b1;

  localparam int DATA_W       = 7;
  localparam int MAX_ITER_DEF = 127;
endpackage

// File: rtl/gcd_iter_cnt.sv
// Subtraction counter: synchronous clear, increment, saturates at MAX_ITER.
module gcd_iter_cnt #(
  parameter int MAX_ITER = 127,
  parameter int CNT_W    = $clog2(MAX_ITER + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             at_max
);
  assign at_max = (cnt == CNT_W'(MAX_ITER));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                cnt <= '0;
    else if (clr)           cnt <= '0;
    else if (inc && !at_max) cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/gcd_ctrl.sv
// Control FSM for the subtractive-GCD datapath (reg_a/reg_b load and select).
// Define GCD_ITER_COUNT_EN to expose the subtraction count as iter_cnt.
module gcd_ctrl
  import gcd_pkg::*;
#(
  parameter int MAX_ITER = MAX_ITER_DEF,
  localparam int CNT_W   = $clog2(MAX_ITER + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             a_gt_b,
  input  logic             a_lt_b,
  input  logic             a_eq_b,
  input  logic             a_zero,
  input  logic             b_zero,
  output logic             a_ld,
  output logic             b_ld,
  output logic             a_sel,
  output logic             b_sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             err,
`ifdef GCD_ITER_COUNT_EN
  output logic [CNT_W-1:0] iter_cnt,
`endif
  output logic             busy
);
  state_t           state, nxt;
  logic             err_q, err_nxt;
  logic             clr, inc, at_max;
  logic [CNT_W-1:0] cnt_q;

  gcd_iter_cnt #(.MAX_ITER(MAX_ITER), .CNT_W(CNT_W)) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .inc   (inc),
    .cnt   (cnt_q),
    .at_max(at_max)
  );

`ifdef GCD_ITER_COUNT_EN
  assign iter_cnt = cnt_q;
`else
  logic unused_cnt;
  assign unused_cnt = ^cnt_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      err_q <= 1'b0;
    end else begin
      state <= nxt;
      err_q <= err_nxt;
    end
  end

  always_comb begin
    nxt       = state;
    err_nxt   = err_q;
    in_ready  = 1'b0;
    a_ld      = 1'b0;
    b_ld      = 1'b0;
    a_sel     = SEL_LOAD;
    b_sel     = SEL_LOAD;
    out_valid = 1'b0;
    busy      = 1'b0;
    clr       = 1'b0;
    inc       = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          a_ld    = 1'b1;
          b_ld    = 1'b1;
          clr     = 1'b1;
          err_nxt = 1'b0;
          nxt     = CMP;
        end
      end
      CMP: begin
        busy = 1'b1;
        // Zero operands would never converge, so they outrank the compare flags.
        if (a_zero || b_zero) begin
          err_nxt = 1'b1;
          nxt     = DONE;
        end else if (a_eq_b) begin
          err_nxt = 1'b0;
          nxt     = DONE;
        end else if (at_max) begin
          err_nxt = 1'b1;
          nxt     = DONE;
        end else if (a_gt_b) begin
          a_ld  = 1'b1;
          a_sel = SEL_SUB;
          inc   = 1'b1;
        end else if (a_lt_b) begin
          b_ld  = 1'b1;
          b_sel = SEL_SUB;
          inc   = 1'b1;
        end else begin
          err_nxt = 1'b1;
          nxt     = DONE;
        end
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  assign err = out_valid & err_q;
endmodule

// File: tb/tb_gcd_ctrl.sv
// Scoreboard bench for gcd_ctrl driving a behavioural reg_a/reg_b datapath.
module tb_gcd_ctrl;
  localparam int MAXI = 4;
  localparam int CW   = $clog2(MAXI + 1);

  logic clk = 1'b0, rst = 1'b1;
  logic in_valid = 1'b0, out_ready = 1'b1;
  logic in_ready, a_ld, b_ld, a_sel, b_sel, out_valid, err, busy;
  logic [6:0] ra = '0, rb = '0, op_a = '0, op_b = '0;
`ifdef GCD_ITER_COUNT_EN
  logic [CW-1:0] iter_cnt;
`endif

  gcd_ctrl #(.MAX_ITER(MAXI)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a_gt_b(ra > rb), .a_lt_b(ra < rb), .a_eq_b(ra == rb),
    .a_zero(ra == 7'd0), .b_zero(rb == 7'd0),
    .a_ld(a_ld), .b_ld(b_ld), .a_sel(a_sel), .b_sel(b_sel),
    .out_valid(out_valid), .out_ready(out_ready), .err(err),
`ifdef GCD_ITER_COUNT_EN
    .iter_cnt(iter_cnt),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (a_ld) ra <= a_sel ? ra - rb : op_a;
    if (b_ld) rb <= b_sel ? rb - ra : op_b;
  end

  typedef struct {int res; int err; int lat; int na; int nb; int iter;} exp_t;
  exp_t q[$];
  int n_chk = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Monitor: tracks accept, strobes and first out_valid; compares at handshake.
  int acc_cyc, rise_cyc, na, nb;
  bit active = 0, rose = 0;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      active = 0;
      rose   = 0;
    end else if (in_valid && in_ready) begin
      chk("accept_strobes", {28'd0, a_ld, b_ld, a_sel, b_sel}, 32'b1100);
      acc_cyc = cyc; active = 1; rose = 0; na = 0; nb = 0;
    end else if (active) begin
      if (a_ld && a_sel) na++;
      if (b_ld && b_sel) nb++;
      if (out_valid && !rose) begin rose = 1; rise_cyc = cyc; end
      if (out_valid && out_ready) begin
        active = 0;
        if (q.size() == 0) chk("unexpected_result", 1, 0);
        else begin
          e = q.pop_front();
          chk("result", 32'(ra), e.res);
          chk("err", 32'(err), e.err);
          chk("latency", rise_cyc - acc_cyc, e.lat);
          chk("a_sub_strobes", na, e.na);
          chk("b_sub_strobes", nb, e.nb);
`ifdef GCD_ITER_COUNT_EN
          chk("iter_cnt", 32'(iter_cnt), e.iter);
`endif
        end
      end
    end
  end

  task automatic issue(input int a, input int b);
    int t = 0;
    @(posedge clk); #1;
    while (!in_ready && t < 200) begin @(posedge clk); #1; t++; end
    if (t >= 200) chk("issue_timeout", 1, 0);
    op_a = 7'(a); op_b = 7'(b); in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while (!in_ready && t < 200) begin @(posedge clk); #1; t++; end
    if (t >= 200) chk("idle_timeout", 1, 0);
  endtask

  task automatic push(input int res, err_v, lat, a_n, b_n, it);
    exp_t e;
    e.res = res; e.err = err_v; e.lat = lat; e.na = a_n; e.nb = b_n; e.iter = it;
    q.push_back(e);
  endtask

  initial begin
    logic [6:0] r_hold;
    logic       e_hold;
    int t;
    repeat (2) @(posedge clk); #1;
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_strobes", {28'd0, a_ld, b_ld, a_sel, b_sel}, 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_err_busy", {30'd0, err, busy}, 0);
`ifdef GCD_ITER_COUNT_EN
    chk("rst_iter_cnt", 32'(iter_cnt), 0);
`endif
    rst = 1'b0;

    push(4, 0, 4, 1, 1, 2);   issue(12, 8);  wait_idle();
    push(7, 0, 2, 0, 0, 0);   issue(7, 7);   wait_idle();
    push(0, 1, 2, 0, 0, 0);   issue(0, 5);   wait_idle();
    push(123, 1, 6, 4, 0, 4); issue(127, 1); wait_idle();

    // Backpressure: result must hold while in_valid pulses are ignored.
    out_ready = 1'b0;
    push(3, 0, 4, 1, 1, 2); issue(9, 6);
    t = 0;
    while (!out_valid && t < 200) begin @(posedge clk); #1; t++; end
    if (t >= 200) chk("done_timeout", 1, 0);
    r_hold = ra; e_hold = err;
    for (int i = 0; i < 5; i++) begin
      op_a = 7'd1; op_b = 7'd1; in_valid = (i % 2 == 0);
      @(posedge clk); #1;
      chk("bp_out_valid", 32'(out_valid), 1);
      chk("bp_err", 32'(err), 32'(e_hold));
      chk("bp_reg_a", 32'(ra), 32'(r_hold));
      chk("bp_in_ready_ld", {29'd0, in_ready, a_ld, b_ld}, 0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    chk("post_hs_in_ready", 32'(in_ready), 1);
    chk("post_hs_out_valid", {30'd0, out_valid, busy}, 0);

    // Asynchronous reset in the middle of a long reduction.
    issue(100, 3);
    @(posedge clk); #1;
    rst = 1'b1; #1;
    chk("mid_rst_in_ready", 32'(in_ready), 1);
    chk("mid_rst_strobes", {29'd0, a_ld, b_ld, out_valid}, 0);
    chk("mid_rst_busy", 32'(busy), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    push(2, 0, 4, 1, 1, 2); issue(6, 4); wait_idle();

    repeat (2) @(posedge clk);
    chk("scoreboard_empty", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
